telemetry_tx_scheduler: RTL
===========================

Name: telemetry_tx_scheduler

Overview:
- Round-robin scheduler that shares one byte-wide UART transmitter between NCH 32-bit telemetry sources (speed, phase current, hall state, duty).
- Grants one requester at a time and captures its word.
- Sequences a 7-byte frame into the transmitter using a start/busy handshake: header, channel id, 4 data bytes MSB first, checksum.
- Sits between the BLDC measurement blocks and the baud-rate serial transmitter.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- HEADER, 8'hA5, frame sync byte.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- CLR  input  1  reset, asynchronous, active-high.
- req  input  NCH  per-channel request, level; held high until the matching ack.
- data_in  input  32*NCH  flattened words; channel k occupies bits [32k+31:32k].
- ack  output  NCH  one-cycle one-hot grant pulse; data_in of that channel is captured in the same cycle.
- tx_byte  output  8  byte to transmitter, stable from tx_start until tx_busy falls.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_byte.
- tx_busy  input  1  transmitter busy, high while shifting a byte.
- sched_busy  output  1  high from grant until the last byte completes.
- frame_cnt  output  16  completed frames, wraps 16'hFFFF -> 0.

Behaviour:
- Reset (CLR=1, async): state=IDLE. ack=0, tx_start=0, tx_byte=0, sched_busy=0, frame_cnt=0. Round-robin pointer last=NCH-1, so channel 0 has first priority. Internal word, id, byte index and checksum are cleared.
- States: IDLE, GRANT, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - If any req=1, go to GRANT.
  - Select the first requesting channel searching last+1, last+2, ... modulo NCH.
- GRANT (1 cycle):
  - ack[sel]=1.
  - Capture word<=data_in[sel], id<=sel.
  - last<=sel, byte index<=0, checksum<=0, sched_busy<=1.
  - Go to SEND.
- SEND (1 cycle):
  - tx_byte<=byte[index], tx_start=1. Go to WAIT_HI.
  - Byte sequence: index 0 HEADER; 1 {5'b0,id} zero-extended to 8 bits; 2 word[31:24]; 3 word[23:16]; 4 word[15:8]; 5 word[7:0]; 6 checksum.
  - Checksum is the XOR of bytes 1..5, accumulated as each is sent. HEADER is excluded.
- WAIT_HI: wait for tx_busy=1.
  - If tx_busy is already 1 at entry, advance next cycle.
  - No timeout.
- WAIT_LO: wait for tx_busy=0.
  - If index<6: index+1, go to SEND.
  - If index=6: frame_cnt+1, sched_busy<=0, go to IDLE.
- Latency:
  - req rise in IDLE -> ack 1 cycle later.
  - ack -> first tx_start 1 cycle later.
  - After each tx_busy fall -> next tx_start 1 cycle later.
- Requests arriving during a frame are not latched. They are evaluated on return to IDLE, so there are no lost or duplicate grants as long as the requester holds req.
- A requester that drops req before its ack is skipped.
- A requester that keeps req high after its ack is re-granted only after every other active channel has had a turn.
- Simultaneous requests: strict rotation, with at most one grant per frame.
- CLR mid-frame: immediate abort to the reset values. tx_start never glitches high. A partial frame may already be on the line, and the receiver resyncs on HEADER.
- tx_busy high in IDLE is ignored.
- ack is never asserted while sched_busy=1.

Test Plan:
- Single request: req=4'b0100, data ch2=32'h12345678 -> ack=4'b0100 one cycle later. tx_byte sequence A5,02,12,34,56,78,0A, with exactly 7 tx_start pulses. frame_cnt=1.
- Round robin: req=4'b1111 held, reasserted after each ack -> grant order 0,1,2,3,0. Each frame carries the matching id and word.
- Contention during frame: ch1 requests while a ch3 frame is in progress -> no ack until the ch3 checksum byte's tx_busy falls. ch1 ack follows 1 cycle after returning to IDLE.
- Handshake timing: transmitter model raises tx_busy 3 cycles after tx_start and holds it 160 cycles -> each next tx_start is exactly 1 cycle after the busy fall. tx_byte is stable during busy.
- Reset mid-frame: assert CLR during byte 4 -> outputs return to 0 asynchronously, frame_cnt=0. After release, a req on ch0 yields a full 7-byte frame starting at A5.
- Dropped request / all-zero data: ch0 req pulses for 0 cycles of grant opportunity while busy -> no ack. ch1 data=0 -> bytes A5,01,00,00,00,00,01.

Source files
------------

// File: rtl/telemetry_tx_scheduler.sv
// Round-robin arbiter that shares one byte-wide UART transmitter between NCH
// 32-bit telemetry sources. Each grant is sent as a 7-byte frame: HEADER, id, word MSB first, XOR checksum.
module telemetry_tx_scheduler #(
  parameter int          NCH    = 4,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [NCH-1:0]    req,
  input  logic [32*NCH-1:0] data_in,
  output logic [NCH-1:0]    ack,
  output logic [7:0]        tx_byte,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              sched_busy,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t      state;
  logic [2:0]  last;
  logic [2:0]  sel;
  logic [2:0]  id;
  logic [2:0]  idx;
  logic [31:0] word;
  logic [7:0]  csum;
  logic [2:0]  rr_sel;
  logic        rr_hit;

  // Returns {hit, channel}: the first requester after 'from', wrapping modulo NCH.
  // The loop runs from the farthest candidate down, so the nearest one is written last and wins.
  function automatic logic [3:0] rr_pick(input logic [NCH-1:0] r, input logic [2:0] from);
    logic [3:0] res;
    int         c;
    res = 4'b0;
    for (int i = NCH; i >= 1; i--) begin
      c = (int'(from) + i) % NCH;
      if (r[c]) res = {1'b1, 3'(c)};
    end
    return res;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [2:0] ch,
                                            input logic [31:0] w, input logic [7:0] cs);
    case (i)
      3'd0:    return HEADER;
      3'd1:    return {5'b0, ch};
      3'd2:    return w[31:24];
      3'd3:    return w[23:16];
      3'd4:    return w[15:8];
      3'd5:    return w[7:0];
      default: return cs;
    endcase
  endfunction

  assign {rr_hit, rr_sel} = rr_pick(req, last);

  // tx_byte and tx_start are loaded on entry to SEND, so tx_start is high exactly for the SEND cycle.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state      <= IDLE;
      ack        <= '0;
      tx_start   <= 1'b0;
      tx_byte    <= 8'h00;
      sched_busy <= 1'b0;
      frame_cnt  <= 16'h0000;
      last       <= 3'(NCH - 1);
      sel        <= 3'd0;
      id         <= 3'd0;
      idx        <= 3'd0;
      word       <= 32'h0;
      csum       <= 8'h00;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_hit) begin
            sel   <= rr_sel;
            ack   <= NCH'(1) << rr_sel;
            state <= GRANT;
          end
        end
        GRANT: begin
          word       <= data_in[32*sel +: 32];
          id         <= sel;
          last       <= sel;
          idx        <= 3'd0;
          csum       <= 8'h00;
          sched_busy <= 1'b1;
          tx_byte    <= HEADER;
          tx_start   <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          // The checksum covers id and data bytes only.
          if (idx != 3'd0 && idx != 3'd6) csum <= csum ^ tx_byte;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (tx_busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (idx == 3'd6) begin
              frame_cnt  <= frame_cnt + 16'd1;
              sched_busy <= 1'b0;
              state      <= IDLE;
            end else begin
              idx      <= 3'(idx + 3'd1);
              tx_byte  <= frame_byte(3'(idx + 3'd1), id, word, csum);
              tx_start <= 1'b1;
              state    <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
